sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer for the SLC-3 board's external asynchronous 16-bit SRAM (1M x 16, active-low CE/UB/LB/OE/WE).
- Port 0 is the CPU; port 1 is the I/O/DMA side (switch/hex I/O, program loader).
- Grants one requester at a time and generates the SRAM strobe sequence with a programmable wait-state count.
- Returns read data and a one-cycle completion pulse.
- Sits between the requesters and the top-level SRAM pins, replacing direct strobe wiring.

Parameters:
- WAIT_CYCLES, 2: cycles CE plus OE/WE stay asserted per access; legal range 1..15.
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- req[1:0]  in  2  per-port access request, level.
- we[1:0]  in  2  per-port write enable (1 = write, 0 = read).
- be0, be1  in  2 each  byte enables {upper, lower}, active-high.
- addr0, addr1  in  ADDR_W each  word address.
- wdata0, wdata1  in  DATA_W each  write data.
- gnt[1:0]  out  2  one-hot grant, high while that port's transaction is in progress.
- rdy[1:0]  out  2  one-cycle completion pulse to the granted port.
- rdata  out  DATA_W  last captured read data, shared by both ports.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.
- A  out  ADDR_W  SRAM address.
- Data_out  out  DATA_W  write data to the pad.
- Data_oe  out  1  pad output enable, 1 = drive Data_out.
- Data_in  in  DATA_W  read data from the pad.

Behaviour:
- Reset low (async) forces:
  - state IDLE; CE/UB/LB/OE/WE = 1.
  - Data_oe = 0; gnt = 0; rdy = 0.
  - A = 0; Data_out = 0; rdata = 0; cnt = 0.
- This applies immediately, including mid-transaction. An aborted transaction produces no rdy. The requester re-issues it after reset.
- All outputs are registered; no combinational path from req to any output.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - All strobes high; Data_oe = 0.
  - If any req bit is set, select a port (arbitration below) and latch its addr, wdata, be and we into A, Data_out and internal registers.
  - Set gnt, load cnt = WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - CE = 0; UB = ~be[1]; LB = ~be[0].
  - Read: OE = 0, WE = 1, Data_oe = 0.
  - Write: WE = 0, OE = 1, Data_oe = 1.
  - cnt decrements each cycle. When cnt == 0: for a read, capture Data_in into rdata at this edge; in both cases go to DONE.
- DONE:
  - CE, OE, WE, UB, LB return to 1.
  - A and Data_out hold. Data_oe holds 1 for writes, giving data hold past the WE rising edge.
  - rdy[granted] = 1 for exactly this cycle; gnt held.
  - Next state IDLE, where gnt and Data_oe drop.
- Latency: rdy is high in the (WAIT_CYCLES+1)th cycle after the edge that samples req. Throughput is one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - The requester holds req, addr, we, be and wdata stable until it sees rdy.
  - It must drop req, or present a new transaction, by the edge ending the rdy cycle.
  - Any req high in IDLE is a new transaction.
  - Inputs are ignored outside IDLE.
- Arbitration (default): fixed priority, port 0 wins simultaneous requests. Port 1 may starve under back-to-back port-0 traffic; this is accepted.
- be = 00: the access still runs the full sequence with UB = LB = 1. rdata is captured but undefined.
- Address range: no wrap or range logic; A is passed through as latched.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant register (reset value 1) is updated when a transaction enters ACCESS.
  - On simultaneous req, the port not equal to last_grant wins; a single req always wins.
  - Each port is served within 2 transactions.
- Undefined: fixed priority as above; last_grant is absent.

Decomposition:
- Shared package slc_mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} sram_state_t;
  - localparams SLC_ADDR_W = 20, SLC_DATA_W = 16, PORT_CPU = 0, PORT_IO = 1.
- One sub-module, mem_req_arb: combinational grant select from req plus last_grant, containing the SRAM_ARB_RR_EN logic. The FSM, counter and pad registers stay in sram_arbiter.

Test Plan:
- Reset: assert Reset = 0 -> CE = OE = WE = UB = LB = 1, Data_oe = 0, gnt = 00, rdy = 00, A = 0x00000. Release, no req -> state remains IDLE.
- Read, port 0, WAIT_CYCLES = 2: addr0 = 0x00123, be0 = 11, Data_in = 0xBEEF ->
  - CE = OE = 0 for exactly 2 cycles, A = 0x00123, UB = LB = 0.
  - rdy[0] pulses in cycle 3; rdata = 0xBEEF; Data_oe stays 0.
- Write, port 1: addr1 = 0xFFFFF, wdata1 = 0x1234, be1 = 01 ->
  - WE = 0 for 2 cycles, LB = 0, UB = 1, OE = 1.
  - Data_out = 0x1234 with Data_oe = 1 through DONE; rdy[1] pulse; gnt = 10.
- Simultaneous req = 11, held after each rdy ->
  - Fixed priority: port 0 is granted every time.
  - SRAM_ARB_RR_EN: grants alternate 0, 1, 0, 1.
- Reset mid-ACCESS: drive Reset = 0 between clock edges -> strobes high and Data_oe = 0 without a clock edge; no rdy. After release, a new req completes normally.
- WAIT_CYCLES = 1 build: back-to-back single-port reads -> CE low 1 cycle per access, rdy every 3 cycles.

Source files
------------

// File: rtl/slc_mem_pkg.sv
// Shared types and constants for the SLC-3 external SRAM path.
// Used by the arbiter, its grant selector and the requester bus.
package slc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } sram_state_t;

  localparam int SLC_ADDR_W = 20;
  localparam int SLC_DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Two-port requester bus into the SRAM arbiter.
// master = requesters (CPU / IO), slave = arbiter.
interface sram_arbiter_if
  import slc_mem_pkg::*;
#(
  parameter int ADDR_W = SLC_ADDR_W,
  parameter int DATA_W = SLC_DATA_W
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        be0;
  logic [1:0]        be1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rdy;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be0, be1,
    output addr0, addr1,
    output wdata0, wdata1,
    input  gnt, rdy, rdata
  );

  modport slave (
    input  req, we, be0, be1,
    input  addr0, addr1,
    input  wdata0, wdata1,
    output gnt, rdy, rdata
  );

endinterface

// File: rtl/mem_req_arb.sv
// Combinational grant select for the SRAM arbiter.
// SRAM_ARB_RR_EN selects round-robin, else fixed priority to port 0.
module mem_req_arb
  import slc_mem_pkg::*;
(
  input  logic [1:0] i_req,
`ifdef SRAM_ARB_RR_EN
  input  logic       i_last_grant,
`endif
  output logic       o_valid,
  output logic       o_port
);

  always_comb begin
    o_valid = |i_req;
    o_port  = PORT_CPU;
    unique case (1'b1)
`ifdef SRAM_ARB_RR_EN
      (i_req == 2'b11): o_port = ~i_last_grant;
`else
      (i_req == 2'b11): o_port = PORT_CPU;
`endif
      (i_req == 2'b10): o_port = PORT_IO;
      default:          o_port = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the async 16-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_arbiter
  import slc_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = SLC_ADDR_W,
  parameter int DATA_W      = SLC_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_arbiter_if.slave     bus,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  sram_state_t       r_state;
  logic [3:0]        r_cnt;
  logic              r_port;
  logic              r_we;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rdy;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ce;
  logic              r_ub;
  logic              r_lb;
  logic              r_oe;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_dout;
  logic              r_doe;

  logic              w_valid;
  logic              w_port;
  logic              w_we;
  logic [1:0]        w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifdef SRAM_ARB_RR_EN
  logic r_last_grant;

  mem_req_arb u_arb (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_port       (w_port)
  );
`else
  mem_req_arb u_arb (
    .i_req   (bus.req),
    .o_valid (w_valid),
    .o_port  (w_port)
  );
`endif

  assign w_we    = w_port ? bus.we[1] : bus.we[0];
  assign w_be    = w_port ? bus.be1   : bus.be0;
  assign w_addr  = w_port ? bus.addr1 : bus.addr0;
  assign w_wdata = w_port ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_port  <= PORT_CPU;
      r_we    <= 1'b0;
      r_gnt   <= '0;
      r_rdy   <= '0;
      r_rdata <= '0;
      r_ce    <= 1'b1;
      r_ub    <= 1'b1;
      r_lb    <= 1'b1;
      r_oe    <= 1'b1;
      r_we_n  <= 1'b1;
      r_a     <= '0;
      r_dout  <= '0;
      r_doe   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      r_last_grant <= PORT_IO;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_port  <= w_port;
            r_we    <= w_we;
            r_a     <= w_addr;
            r_dout  <= w_wdata;
            r_gnt   <= w_port ? 2'b10 : 2'b01;
            r_cnt   <= CNT_INIT;
            // strobes go live on the same edge so ACCESS is W cycles
            r_ce    <= 1'b0;
            r_ub    <= ~w_be[1];
            r_lb    <= ~w_be[0];
            r_oe    <= w_we;
            r_we_n  <= ~w_we;
            r_doe   <= w_we;
            r_state <= ACCESS;
`ifdef SRAM_ARB_RR_EN
            r_last_grant <= w_port;
`endif
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) r_rdata <= Data_in;
            r_ce    <= 1'b1;
            r_ub    <= 1'b1;
            r_lb    <= 1'b1;
            r_oe    <= 1'b1;
            r_we_n  <= 1'b1;
            r_rdy   <= r_port ? 2'b10 : 2'b01;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_rdy   <= '0;
          r_gnt   <= '0;
          r_doe   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.rdy   = r_rdy;
  assign bus.rdata = r_rdata;

  assign CE       = r_ce;
  assign UB       = r_ub;
  assign LB       = r_lb;
  assign OE       = r_oe;
  assign WE       = r_we_n;
  assign A        = r_a;
  assign Data_out = r_dout;
  assign Data_oe  = r_doe;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_CYCLES=2 main DUT plus a
// WAIT_CYCLES=1 instance for back-to-back timing.
module tb_sram_arbiter;

  logic Clk;
  logic Reset;

  logic        CE, UB, LB, OE, WE, Data_oe;
  logic [19:0] A;
  logic [15:0] Data_out, Data_in;

  logic        ce1, ub1, lb1, oe1, we1, doe1;
  logic [19:0] a1;
  logic [15:0] dout1, din1;

  int n_chk;
  int n_err;

  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus0 ();
  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus0),
    .CE       (CE),
    .UB       (UB),
    .LB       (LB),
    .OE       (OE),
    .WE       (WE),
    .A        (A),
    .Data_out (Data_out),
    .Data_oe  (Data_oe),
    .Data_in  (Data_in)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus1),
    .CE       (ce1),
    .UB       (ub1),
    .LB       (lb1),
    .OE       (oe1),
    .WE       (we1),
    .A        (a1),
    .Data_out (dout1),
    .Data_oe  (doe1),
    .Data_in  (din1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4:0] strb;
    strb = {CE, OE, WE, UB, LB};
  endfunction

  initial begin
    logic [1:0] g_exp;
    n_chk = 0;
    n_err = 0;
    Reset = 1'b0;
    Data_in = '0;
    din1 = '0;
    bus0.req = '0;  bus0.we = '0;
    bus0.be0 = '0;  bus0.be1 = '0;
    bus0.addr0 = '0; bus0.addr1 = '0;
    bus0.wdata0 = '0; bus0.wdata1 = '0;
    bus1.req = '0;  bus1.we = '0;
    bus1.be0 = '0;  bus1.be1 = '0;
    bus1.addr0 = '0; bus1.addr1 = '0;
    bus1.wdata0 = '0; bus1.wdata1 = '0;

    // reset state
    tick; tick;
    chk("rst_strb", strb(), 5'b11111);
    chk("rst_doe", Data_oe, 1'b0);
    chk("rst_gnt", bus0.gnt, 2'b00);
    chk("rst_rdy", bus0.rdy, 2'b00);
    chk("rst_a", A, 20'h00000);
    chk("rst_rdata", bus0.rdata, 16'h0);
    Reset = 1'b1;
    tick; tick;
    chk("idle_gnt", bus0.gnt, 2'b00);
    chk("idle_strb", strb(), 5'b11111);

    // read, port 0
    bus0.addr0 = 20'h00123;
    bus0.be0 = 2'b11;
    bus0.we = 2'b00;
    Data_in = 16'hBEEF;
    bus0.req = 2'b01;
    tick;
    chk("rd_strb1", strb(), 5'b00100);
    chk("rd_a", A, 20'h00123);
    chk("rd_gnt", bus0.gnt, 2'b01);
    chk("rd_doe1", Data_oe, 1'b0);
    chk("rd_rdy1", bus0.rdy, 2'b00);
    tick;
    chk("rd_strb2", strb(), 5'b00100);
    chk("rd_rdy2", bus0.rdy, 2'b00);
    tick;
    chk("rd_strb3", strb(), 5'b11111);
    chk("rd_rdy3", bus0.rdy, 2'b01);
    chk("rd_rdata", bus0.rdata, 16'hBEEF);
    chk("rd_doe3", Data_oe, 1'b0);
    bus0.req = 2'b00;
    tick;
    chk("rd_gnt4", bus0.gnt, 2'b00);
    chk("rd_rdy4", bus0.rdy, 2'b00);

    // write, port 1
    bus0.addr1 = 20'hFFFFF;
    bus0.wdata1 = 16'h1234;
    bus0.be1 = 2'b01;
    bus0.we = 2'b10;
    bus0.req = 2'b10;
    tick;
    chk("wr_strb1", strb(), 5'b01010);
    chk("wr_a", A, 20'hFFFFF);
    chk("wr_dout", Data_out, 16'h1234);
    chk("wr_doe1", Data_oe, 1'b1);
    chk("wr_gnt", bus0.gnt, 2'b10);
    tick;
    chk("wr_strb2", strb(), 5'b01010);
    tick;
    chk("wr_strb3", strb(), 5'b11111);
    chk("wr_doe3", Data_oe, 1'b1);
    chk("wr_dout3", Data_out, 16'h1234);
    chk("wr_rdy", bus0.rdy, 2'b10);
    chk("wr_gnt3", bus0.gnt, 2'b10);
    bus0.req = 2'b00;
    tick;
    chk("wr_doe4", Data_oe, 1'b0);
    chk("wr_gnt4", bus0.gnt, 2'b00);

    // simultaneous requests, both held
    bus0.we = 2'b00;
    bus0.be0 = 2'b11;
    bus0.be1 = 2'b11;
    bus0.addr0 = 20'h00010;
    bus0.addr1 = 20'h00020;
    bus0.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      g_exp = 2'b01;
`endif
      tick;
      chk("arb_gnt", bus0.gnt, g_exp);
      chk("arb_a", A, g_exp[1] ? 20'h00020 : 20'h00010);
      tick;
      tick;
      chk("arb_rdy", bus0.rdy, g_exp);
      tick;
    end
    bus0.req = 2'b00;
    tick;

    // byte enables 00: full sequence, UB/LB idle
    bus0.be0 = 2'b00;
    bus0.req = 2'b01;
    tick;
    chk("be0_strb", strb(), 5'b00111);
    tick;
    tick;
    chk("be0_rdy", bus0.rdy, 2'b01);
    bus0.req = 2'b00;
    tick;

    // reset in the middle of a write
    bus0.addr0 = 20'h00777;
    bus0.wdata0 = 16'hCAFE;
    bus0.be0 = 2'b11;
    bus0.we = 2'b01;
    bus0.req = 2'b01;
    tick;
    chk("mid_doe_pre", Data_oe, 1'b1);
    #3 Reset = 1'b0;
    #1;
    chk("mid_strb", strb(), 5'b11111);
    chk("mid_doe", Data_oe, 1'b0);
    chk("mid_gnt", bus0.gnt, 2'b00);
    chk("mid_a", A, 20'h00000);
    bus0.req = 2'b00;
    tick;
    chk("mid_rdy", bus0.rdy, 2'b00);
    Reset = 1'b1;
    tick;
    chk("mid_rdy2", bus0.rdy, 2'b00);
    bus0.addr0 = 20'h00042;
    bus0.we = 2'b00;
    Data_in = 16'h5A5A;
    bus0.req = 2'b01;
    tick;
    chk("rec_strb", strb(), 5'b00100);
    tick;
    tick;
    chk("rec_rdy", bus0.rdy, 2'b01);
    chk("rec_rdata", bus0.rdata, 16'h5A5A);
    bus0.req = 2'b00;
    tick;

    // WAIT_CYCLES=1: back-to-back reads
    bus1.addr0 = 20'h00ABC;
    bus1.be0 = 2'b11;
    din1 = 16'h1357;
    bus1.req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("w1_ce_acc", ce1, 1'b0);
      chk("w1_rdy_acc", bus1.rdy, 2'b00);
      tick;
      chk("w1_ce_done", ce1, 1'b1);
      chk("w1_rdy_done", bus1.rdy, 2'b01);
      chk("w1_rdata", bus1.rdata, 16'h1357);
      tick;
      chk("w1_ce_idle", ce1, 1'b1);
      chk("w1_rdy_idle", bus1.rdy, 2'b00);
    end
    bus1.req = 2'b00;
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
